// File: rtl/tick_period_meter_if.sv
// Result channel of tick_period_meter.
// Carries one period measurement with valid/ready flow control. The
// missed pulse travels with the result because it reports results
// that were dropped on this channel.
//   period   : measured cycles between the last two tick rising edges
//   overflow : interval exceeded 2^NBITS-1, period is saturated
//   valid    : period/overflow hold a result
//   ready    : consumer accepts the result when valid & ready
//   missed   : one-cycle pulse, a completed measurement was dropped
interface tick_period_meter_if #(
   parameter int unsigned NBITS = 16
);
   logic [NBITS-1:0] period;
   logic             overflow;
   logic             valid;
   logic             ready;
   logic             missed;

   modport master (
      output period,
      output overflow,
      output valid,
      output missed,
      input  ready
   );

   modport slave (
      input  period,
      input  overflow,
      input  valid,
      input  missed,
      output ready
   );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the number of clk cycles between consecutive rising edges of
// tick and delivers each measurement on a valid/ready result channel.
// The counter saturates instead of wrapping. A measurement that
// completes while the previous one is still waiting is dropped and
// flagged on missed.
//   clk  : clock, all logic on rising edge
//   rst  : synchronous active-low reset
//   en   : measurement enable
//   tick : tick input, events are rising edges sampled on clk
//   res  : result channel (period, overflow, valid, ready, missed)
module tick_period_meter #(
   parameter int unsigned NBITS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       tick,
   tick_period_meter_if.master        res
);

   localparam int unsigned W = NBITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   cnt, cnt_nxt;
   logic           sat, sat_nxt;
   logic           tick_q;
   logic [W-1:0]   period_q, period_nxt;
   logic           overflow_q, overflow_nxt;
   logic           valid_q, valid_nxt;
   logic           missed_q, missed_nxt;
   logic           event_c;
   logic           slot_free_c;

   // Rising edge of tick; tick_q resets high so a tick already high at
   // reset release is not an event.
   assign event_c = tick & ~tick_q;

   // Output slot can take a new result if empty or drained this cycle.
   assign slot_free_c = ~valid_q | res.ready;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sat        <= 1'b0;
         tick_q     <= 1'b1;
         period_q   <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sat        <= sat_nxt;
         tick_q     <= tick;
         period_q   <= period_nxt;
         overflow_q <= overflow_nxt;
         valid_q    <= valid_nxt;
         missed_q   <= missed_nxt;
      end
   end

   // Next-state, counter and result-slot logic.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      sat_nxt      = sat;
      period_nxt   = period_q;
      overflow_nxt = overflow_q;
      valid_nxt    = valid_q & ~res.ready;
      missed_nxt   = 1'b0;

      if (!en) begin
         // Partial interval is discarded; a pending result stays put.
         state_nxt = IDLE;
         cnt_nxt   = '0;
         sat_nxt   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // An event in the cycle en rises is ignored here.
               state_nxt = ARMED;
               cnt_nxt   = '0;
               sat_nxt   = 1'b0;
            end
            ARMED: begin
               cnt_nxt = '0;
               sat_nxt = 1'b0;
               if (event_c) begin
                  state_nxt = MEASURE;
                  cnt_nxt   = W'(1);
               end
            end
            MEASURE: begin
               if (event_c) begin
                  cnt_nxt = W'(1);
                  sat_nxt = 1'b0;
                  if (slot_free_c) begin
                     period_nxt   = cnt;
                     overflow_nxt = sat;
                     valid_nxt    = 1'b1;
                  end else begin
                     missed_nxt = 1'b1;
                  end
               end else if (cnt == {W{1'b1}}) begin
                  // Increment attempted at the top: hold and remember it.
                  sat_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               sat_nxt   = 1'b0;
            end
         endcase
      end
   end

   assign res.period   = period_q;
   assign res.overflow = overflow_q;
   assign res.valid    = valid_q;
   assign res.missed   = missed_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with NBITS=8. Inputs change 1ns
// after a rising edge; outputs are sampled at the same point, so each
// check sees the state produced by the edge just passed.
module tb_tick_period_meter;

   localparam int unsigned NB = 8;

   logic clk;
   logic rst;
   logic en;
   logic tick;

   int n_tests;
   int n_fail;

   tick_period_meter_if #(.NBITS(NB)) res_if ();

   tick_period_meter #(.NBITS(NB)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick),
      .res  (res_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // n cycles with tick low.
   task automatic gap(input int n);
      tick = 1'b0;
      repeat (n) cyc();
   endtask

   // One-cycle tick pulse; the edge's result is visible on return.
   task automatic pulse();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [7:0] p, input logic o);
      check({tag, ".valid"}, 32'(res_if.valid), 32'd1);
      check({tag, ".period"}, 32'(res_if.period), 32'(p));
      check({tag, ".overflow"}, 32'(res_if.overflow), 32'(o));
      check({tag, ".missed"}, 32'(res_if.missed), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst  = 1'b0;
      en   = 1'b0;
      tick = 1'b1;
      res_if.ready = 1'b0;

      // 1. Reset with tick high.
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst.valid", 32'(res_if.valid), 32'd0);
         check("rst.period", 32'(res_if.period), 32'd0);
         check("rst.overflow", 32'(res_if.overflow), 32'd0);
         check("rst.missed", 32'(res_if.missed), 32'd0);
      end
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("rel.valid", 32'(res_if.valid), 32'd0);
         check("rel.missed", 32'(res_if.missed), 32'd0);
      end

      // 2. Steady period of 10, ready held high.
      res_if.ready = 1'b1;
      gap(2);
      pulse();
      check("first.valid", 32'(res_if.valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         gap(9);
         check("steady.idle", 32'(res_if.valid), 32'd0);
         pulse();
         expect_result("steady", 8'd10, 1'b0);
      end
      gap(9);
      for (int k = 0; k < 2; k++) begin
         tick = 1'b1;
         cyc();
         expect_result("wide", 8'd10, 1'b0);
         cyc();
         check("wide.drop", 32'(res_if.valid), 32'd0);
         cyc();
         gap(7);
      end

      // 3. Overflow: 300-cycle interval saturates, then 20.
      pulse();
      expect_result("pre_ovf", 8'd10, 1'b0);
      gap(299);
      pulse();
      expect_result("ovf", 8'd255, 1'b1);
      gap(19);
      pulse();
      expect_result("post_ovf", 8'd20, 1'b0);

      // 4. Backpressure with 5-cycle edges.
      gap(4);
      res_if.ready = 1'b0;
      pulse();
      expect_result("bp.first", 8'd5, 1'b0);
      for (int k = 0; k < 2; k++) begin
         gap(4);
         pulse();
         check("bp.valid", 32'(res_if.valid), 32'd1);
         check("bp.period", 32'(res_if.period), 32'd5);
         check("bp.missed", 32'(res_if.missed), 32'd1);
         cyc();
         check("bp.missed_clr", 32'(res_if.missed), 32'd0);
         check("bp.hold", 32'(res_if.valid), 32'd1);
         gap(2);
         if (k == 0) begin
            check("bp.hold2", 32'(res_if.valid), 32'd1);
         end else begin
            res_if.ready = 1'b1;
            cyc();
            check("bp.accept", 32'(res_if.valid), 32'd0);
            res_if.ready = 1'b0;
            gap(0);
         end
      end
      // last iteration used 1+2+1 = 4 idle cycles, so this edge is 5 after
      pulse();
      expect_result("bp.resume", 8'd5, 1'b0);

      // 5. Accept and capture in the same cycle.
      res_if.ready = 1'b1;
      cyc();
      check("acc.drain", 32'(res_if.valid), 32'd0);
      res_if.ready = 1'b0;
      gap(4);
      pulse();
      expect_result("acc.six", 8'd6, 1'b0);
      gap(8);
      check("acc.pending", 32'(res_if.period), 32'd6);
      res_if.ready = 1'b1;
      pulse();
      expect_result("acc.nine", 8'd9, 1'b0);
      cyc();
      check("acc.fall", 32'(res_if.valid), 32'd0);

      // 6a. Drop en mid-interval.
      gap(3);
      pulse();
      cyc();
      check("abort.accepted", 32'(res_if.valid), 32'd0);
      gap(2);
      en = 1'b0;
      cyc();
      en = 1'b1;
      gap(4);
      pulse();
      check("abort.no_result", 32'(res_if.valid), 32'd0);
      check("abort.no_missed", 32'(res_if.missed), 32'd0);
      gap(6);
      res_if.ready = 1'b0;
      pulse();
      expect_result("abort.true", 8'd7, 1'b0);

      // 6b. Reset while a result is pending.
      gap(3);
      check("rst_mid.pending", 32'(res_if.valid), 32'd1);
      rst = 1'b0;
      cyc();
      check("rst_mid.valid", 32'(res_if.valid), 32'd0);
      check("rst_mid.period", 32'(res_if.period), 32'd0);
      rst = 1'b1;
      res_if.ready = 1'b1;
      gap(3);
      pulse();
      check("rst_mid.first", 32'(res_if.valid), 32'd0);
      gap(4);
      pulse();
      expect_result("rst_mid.after", 8'd5, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the interval, in clock cycles, between consecutive rising edges of a tick input and delivers each measurement over a valid/ready output. It is the receiving end of our tick generators: it consumes the `tick` output of a timer and reports the actual tick period. Typical uses are rate checking and feeding downstream logic that adapts to the tick rate. Measurement saturates rather than wraps, and results that cannot be delivered are reported as lost.

## Interface
- `NBITS`, default 16: width of the period counter and of the `period` output; maximum reportable period is 2^NBITS-1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  measurement enable.
- `tick`  in  1  tick input; events are rising edges, sampled on `clk`.
- `period`  out  NBITS  measured cycles between the last two rising edges.
- `overflow`  out  1  qualifies `period`: the interval exceeded 2^NBITS-1 and `period` is saturated.
- `valid`  out  1  `period` and `overflow` hold a result.
- `ready`  in  1  consumer accepts the result when `valid` and `ready` are both high.
- `missed`  out  1  one-cycle pulse: a completed measurement was dropped because the output was still occupied.

## Operation
- **Edge detection:** `tick_q` is `tick` registered. The event is `tick & ~tick_q`.
  - A tick held high for several cycles counts as one event.
  - `tick_q` resets to 1, so a tick that is high when reset releases is not an event.
- **States:**
  - IDLE: entered from any state when `en`=0. The counter is held at 0.
  - ARMED: `en`=1, waiting for the first event. The counter is held at 0.
  - MEASURE: interval in progress.
- **Transitions:**
  - IDLE→ARMED when `en`=1.
  - ARMED→MEASURE on an event; the counter loads 1.
  - In MEASURE, on each event the result is captured, the counter reloads 1, and the state stays MEASURE.
  - Any state→IDLE when `en`=0, taking effect the next cycle. The partial interval is discarded and a pending result is kept.
- **Counting:**
  - In MEASURE without an event, the counter increments by 1 per cycle and saturates at 2^NBITS-1.
  - A sticky `sat` bit is set when an increment is attempted at the maximum value. `sat` is cleared on reload.
  - For edges at cycles t0 and t1, the result is t1-t0. The minimum possible result is 2, because edges need a low cycle between them.
- **Capture on event in MEASURE:**
  - If the output slot is free, or `valid`&`ready` in the same cycle: load `period`=counter value and `overflow`=`sat`; `valid`=1.
  - Otherwise `missed`=1 for that cycle and the held result is unchanged.
- **Handshake:**
  - `valid`, once high, stays high with stable `period`/`overflow` until a cycle with `ready`=1.
  - After that cycle, `valid` falls unless a new capture happens in the same cycle.
- **Reset** (`rst`=0 at a clock edge): state IDLE, counter 0, `sat` 0, `tick_q` 1. Outputs `period`=0, `overflow`=0, `valid`=0, `missed`=0. Reset mid-measurement discards everything, including a pending result.

## Timing
- Event sampled at edge t1: `valid`, `period` and `overflow` are visible after edge t1 (latency 1 cycle from tick rising).
- `missed` is registered and asserts after the same edge as the dropped capture would have.
- `en` rising: the first event may arrive in the cycle after `en` is sampled high. An event in the same cycle `en` rises is ignored.
- `ready` is combinationally ignored when `valid`=0; no output depends combinationally on any input.

## Test plan
1. **Reset behaviour:** hold `rst`=0 for 3 cycles with `tick`=1, then release.
   - During reset: all outputs 0.
   - After release, with `tick` held high: no `valid`, no `missed`.
2. **Steady period:** NBITS=8, `en`=1, `ready`=1, `tick` 1-cycle pulses every 10 cycles.
   - First edge: no `valid`.
   - Each later edge: `valid` for 1 cycle with `period`=10, `overflow`=0.
   - A 3-cycle-wide tick at the same period also gives 10.
3. **Overflow:** NBITS=8, edges 300 cycles apart → `period`=255, `overflow`=1. The next 20-cycle interval → `period`=20, `overflow`=0.
4. **Backpressure:** `ready`=0, edges every 5 cycles.
   - `valid` holds `period`=5 and `missed` pulses at each later edge.
   - Then raise `ready` for 1 cycle away from an edge → `valid` falls the next cycle.
5. **Simultaneous accept and capture:** edge intervals 6 then 9, with `ready`=1 exactly in the capture cycle of the 9-cycle interval while `valid`=1.
   - `valid` stays 1, `period` changes 6→9, `missed`=0.
6. **Mid-measurement abort:**
   - Drop `en` 4 cycles after an edge, then restore it: the next edge produces no result, and the one after it reports the true period.
   - Repeat with `rst`=0 pulsed mid-interval while a result is pending: `valid`→0 immediately after the reset edge.
